pls_load_gen: RTL and testbench
===============================

Name: pls_load_gen

Overview:
- Pulse-train transmitter for the watch's clear/pulse counter interface.
- On request, emits one clear pulse, then exactly N count pulses, so a downstream mod-60 counter (seconds/minutes) is preset to value N.
- Sits between the time-set control logic and the counter chain; drives the counter's clr and plsi inputs.
- Pulse widths are stretched so the counter's two-flop input synchronisers and edge detectors catch every edge.

Parameters:
- WIDTH, 6, width of the target value and internal pulse counter
- MAX_VAL, 59, largest legal target; larger targets are clamped to this value
- CLR_W, 4, clr_o high time in clk cycles (legal range 2..255)
- PLS_HIGH, 4, plso high time per pulse in clk cycles (legal range 2..255)
- PLS_LOW, 4, low time after clr and after each pulse in clk cycles (legal range 2..255)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  load request; sampled only in IDLE
- abort  input  1  cancels a sequence in progress
- target  input  WIDTH  value to load; captured on the accepted start
- clr_o  output  1  clear pulse to the counter
- plso  output  1  count pulse train to the counter
- busy  output  1  high while a sequence is in progress
- done  output  1  one-cycle completion strobe
- clamp  output  1  one-cycle strobe coincident with done when target was clamped

Behaviour:
- Reset (rst=1, asynchronous): state=IDLE, clr_o=0, plso=0, busy=0, done=0, clamp=0, timers=0. Reset mid-sequence drops clr_o/plso immediately; no done is produced.
- All outputs are registered. No combinational path from any input to any output.
- States: IDLE, CLR_HI, CLR_GAP, PLS_HI, PLS_LO, FIN.
- IDLE
  - start=1 at edge E0: latch N = min(target, MAX_VAL) and clamp flag (target>MAX_VAL); go to CLR_HI.
  - From the cycle after E0: clr_o=1, busy=1.
- CLR_HI: clr_o high for exactly CLR_W cycles, then CLR_GAP.
- CLR_GAP: all lines low for PLS_LOW cycles.
  - Then PLS_HI if N>0, else FIN.
- PLS_HI: plso high for PLS_HIGH cycles, then PLS_LO.
- PLS_LO: plso low for PLS_LOW cycles.
  - Increment the sent count at entry.
  - On expiry: PLS_HI if sent<N, else FIN.
- FIN: for exactly one cycle, done=1, clamp=latched flag, busy=0. Then IDLE.
- Latency: done is high in cycle T counted from the first clr_o-high cycle (cycle 0), with T = CLR_W + PLS_LOW + N*(PLS_HIGH+PLS_LOW). Defaults: N=0 gives T=8; N=59 gives T=480.
- clr_o and plso are never high in the same cycle. Each pulse is followed by at least PLS_LOW low cycles, so the receiver sees every falling edge.
- start while busy=1 (or while in FIN) is ignored; target changes after capture have no effect.
- abort=1 in any non-IDLE state:
  - Next edge goes to IDLE; clr_o=0, plso=0, busy=0.
  - done and clamp stay 0.
  - abort has priority over timer expiry in the same cycle.
  - abort in IDLE has no effect, and start is ignored in that cycle.
- start and abort both high in IDLE: abort wins, no sequence starts.
- Timers are 8-bit down-counters loaded with (param-1). Pulse counter is WIDTH bits and never wraps, since N ≤ MAX_VAL < 2^WIDTH.

Test Plan:
- Reset then idle, start=0 for 20 cycles -> all outputs 0.
- target=0, start 1 cycle -> clr_o high cycles 0-3, no plso pulses, done=1 at cycle 8, clamp=0.
- target=3, defaults -> plso high cycles 8-11, 16-19, 24-27; done at cycle 32. A connected pls_cnt_60 reads qout=3 afterwards.
- target=63 -> 59 plso pulses, done at cycle 480 with clamp=1; downstream counter reads 59.
- target=10, abort asserted during the 4th plso high period -> plso falls next cycle, busy=0, no done. A new start with target=5 then completes normally with 5 pulses.
- target=2, start re-pulsed mid-sequence with target=7, then rst pulsed during PLS_HI -> re-start ignored; rst drops plso immediately and all outputs stay 0 until the next start.

Source files
------------

// File: rtl/pls_load_gen_if.sv
// Handshake bundle between the time-set control (master) and the
// clear/pulse load generator (slave).
interface pls_load_gen_if #(
  parameter int WIDTH = 6
);
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] target;
  logic             clr_o;
  logic             plso;
  logic             busy;
  logic             done;
  logic             clamp;

  modport master (
    output start, abort, target,
    input  clr_o, plso, busy, done, clamp
  );

  modport slave (
    input  start, abort, target,
    output clr_o, plso, busy, done, clamp
  );
endinterface

// File: rtl/pls_load_gen.sv
// Presets a downstream mod-60 pulse counter to N: one stretched clear pulse
// followed by exactly N stretched count pulses, each trailed by a low gap.
module pls_load_gen #(
  parameter int WIDTH    = 6,
  parameter int MAX_VAL  = 59,
  parameter int CLR_W    = 4,
  parameter int PLS_HIGH = 4,
  parameter int PLS_LOW  = 4
) (
  input  logic            clk,
  input  logic            rst,
  pls_load_gen_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLR_HI  = 3'd1,
    CLR_GAP = 3'd2,
    PLS_HI  = 3'd3,
    PLS_LO  = 3'd4,
    FIN     = 3'd5
  } state_t;

  localparam logic [7:0]       CLR_LD  = 8'(CLR_W - 1);
  localparam logic [7:0]       HIGH_LD = 8'(PLS_HIGH - 1);
  localparam logic [7:0]       LOW_LD  = 8'(PLS_LOW - 1);
  localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ONE_V   = WIDTH'(1);

  state_t           state_q, state_d;
  logic [7:0]       tmr_q, tmr_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH-1:0] sent_q, sent_d;
  logic             clamp_flag_q, clamp_flag_d;
  logic             clr_q, clr_d;
  logic             plso_q, plso_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             clamp_q, clamp_d;

  // Next-state and next-output computation for the load sequencer.
  always_comb begin
    state_d      = state_q;
    tmr_d        = tmr_q;
    n_d          = n_q;
    sent_d       = sent_q;
    clamp_flag_d = clamp_flag_q;
    clr_d        = clr_q;
    plso_d       = plso_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    clamp_d      = 1'b0;

    // Abort outranks any timer expiry; it only matters once a sequence runs.
    if ((state_q != IDLE) && bus.abort) begin
      state_d = IDLE;
      tmr_d   = 8'd0;
      clr_d   = 1'b0;
      plso_d  = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            state_d = CLR_HI;
            tmr_d   = CLR_LD;
            sent_d  = '0;
            clr_d   = 1'b1;
            busy_d  = 1'b1;
            if (bus.target > MAX_V) begin
              n_d          = MAX_V;
              clamp_flag_d = 1'b1;
            end else begin
              n_d          = bus.target;
              clamp_flag_d = 1'b0;
            end
          end else begin
            state_d = IDLE;
          end
        end
        CLR_HI: begin
          if (tmr_q == 8'd0) begin
            state_d = CLR_GAP;
            tmr_d   = LOW_LD;
            clr_d   = 1'b0;
          end else begin
            tmr_d = tmr_q - 8'd1;
          end
        end
        CLR_GAP: begin
          if (tmr_q == 8'd0) begin
            if (n_q != '0) begin
              state_d = PLS_HI;
              tmr_d   = HIGH_LD;
              plso_d  = 1'b1;
            end else begin
              state_d = FIN;
              done_d  = 1'b1;
              clamp_d = clamp_flag_q;
              busy_d  = 1'b0;
            end
          end else begin
            tmr_d = tmr_q - 8'd1;
          end
        end
        PLS_HI: begin
          if (tmr_q == 8'd0) begin
            state_d = PLS_LO;
            tmr_d   = LOW_LD;
            plso_d  = 1'b0;
            sent_d  = sent_q + ONE_V;
          end else begin
            tmr_d = tmr_q - 8'd1;
          end
        end
        PLS_LO: begin
          if (tmr_q == 8'd0) begin
            if (sent_q < n_q) begin
              state_d = PLS_HI;
              tmr_d   = HIGH_LD;
              plso_d  = 1'b1;
            end else begin
              state_d = FIN;
              done_d  = 1'b1;
              clamp_d = clamp_flag_q;
              busy_d  = 1'b0;
            end
          end else begin
            tmr_d = tmr_q - 8'd1;
          end
        end
        FIN: begin
          state_d = IDLE;
          tmr_d   = 8'd0;
        end
        default: begin
          state_d = IDLE;
          tmr_d   = 8'd0;
          clr_d   = 1'b0;
          plso_d  = 1'b0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // Sequencer state and registered outputs, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      tmr_q        <= 8'd0;
      n_q          <= '0;
      sent_q       <= '0;
      clamp_flag_q <= 1'b0;
      clr_q        <= 1'b0;
      plso_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      clamp_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      n_q          <= n_d;
      sent_q       <= sent_d;
      clamp_flag_q <= clamp_flag_d;
      clr_q        <= clr_d;
      plso_q       <= plso_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      clamp_q      <= clamp_d;
    end
  end

  assign bus.clr_o = clr_q;
  assign bus.plso  = plso_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.clamp = clamp_q;

endmodule

// File: tb/tb_pls_load_gen.sv
// Bench for pls_load_gen: expected waveforms are derived per cycle from the
// pulse-train timing rules, plus a mod-60 counter fed by the DUT lines.
module tb_pls_load_gen;
  localparam int WIDTH = 6;
  localparam int MAXV  = 59;
  localparam int CW    = 4;
  localparam int PH    = 4;
  localparam int PL    = 4;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  pls_load_gen_if #(.WIDTH(WIDTH)) bus ();

  pls_load_gen #(
    .WIDTH(WIDTH), .MAX_VAL(MAXV), .CLR_W(CW), .PLS_HIGH(PH), .PLS_LOW(PL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_clr"},   32'(bus.clr_o), 32'd0);
    chk({tag, "_plso"},  32'(bus.plso),  32'd0);
    chk({tag, "_busy"},  32'(bus.busy),  32'd0);
    chk({tag, "_done"},  32'(bus.done),  32'd0);
    chk({tag, "_clamp"}, 32'(bus.clamp), 32'd0);
  endtask

  task automatic idle_cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk_quiet(tag);
    end
  endtask

  // Start a load of tgt; optionally abort (abort_c) or reset (rst_c) at a cycle.
  task automatic run_seq(input int tgt, input int abort_c, input int rst_c);
    int n, t, per, off, stop_c, cnt;
    bit clamp_f, e_clr, e_pls, e_busy, e_done, e_clamp, prev_p;
    n       = (tgt > MAXV) ? MAXV : tgt;
    clamp_f = (tgt > MAXV);
    per     = PH + PL;
    t       = CW + PL + n * per;
    stop_c  = (abort_c >= 0) ? abort_c : rst_c;
    cnt     = 0;
    prev_p  = 1'b0;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.target = WIDTH'(tgt);
    bus.abort  = 1'b0;
    @(negedge clk);
    for (int c = 0; c <= t + 1; c++) begin
      if (stop_c >= 0 && c > stop_c) begin
        e_clr = 0; e_pls = 0; e_busy = 0; e_done = 0; e_clamp = 0;
      end else begin
        off     = c - (CW + PL);
        e_clr   = (c < CW);
        e_pls   = (off >= 0) && (off < n * per) && ((off % per) < PH);
        e_busy  = (c < t);
        e_done  = (c == t);
        e_clamp = (c == t) && clamp_f;
      end
      chk("seq_clr",   32'(bus.clr_o), 32'(e_clr));
      chk("seq_plso",  32'(bus.plso),  32'(e_pls));
      chk("seq_busy",  32'(bus.busy),  32'(e_busy));
      chk("seq_done",  32'(bus.done),  32'(e_done));
      chk("seq_clamp", 32'(bus.clamp), 32'(e_clamp));
      if (bus.clr_o === 1'b1) cnt = 0;
      else if (bus.plso === 1'b1 && !prev_p) cnt = (cnt + 1) % 60;
      prev_p = (bus.plso === 1'b1);
      // Noise on start/target while busy must be ignored.
      if (c <= t && !(stop_c >= 0 && c >= stop_c + (rst_c >= 0 ? 0 : 1)))
        bus.start = 1'($urandom_range(0, 1));
      else
        bus.start = 1'b0;
      bus.target = WIDTH'($urandom_range(0, 63));
      bus.abort  = (c == abort_c);
      if (c == rst_c) begin
        rst = 1'b1;
        #1;
        chk("rst_async_plso", 32'(bus.plso),  32'd0);
        chk("rst_async_clr",  32'(bus.clr_o), 32'd0);
        chk("rst_async_busy", 32'(bus.busy),  32'd0);
      end else if (c == rst_c + 1) begin
        rst = 1'b0;
      end else begin
        rst = rst;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    rst       = 1'b0;
    if (stop_c < 0) chk("downstream_count", 32'(cnt), 32'(n));
  endtask

  initial begin
    int tgt, t, ab;
    checks     = 0;
    failures   = 0;
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.abort  = 1'b0;
    bus.target = '0;
    idle_cycles(3, "in_reset");
    rst = 1'b0;
    idle_cycles(20, "idle");

    run_seq(0, -1, -1);
    run_seq(3, -1, -1);
    run_seq(63, -1, -1);
    run_seq(10, 33, -1);
    run_seq(5, -1, -1);
    run_seq(2, -1, 9);
    idle_cycles(10, "after_rst");

    // start together with abort in IDLE: abort wins.
    @(negedge clk);
    bus.start  = 1'b1;
    bus.abort  = 1'b1;
    bus.target = 6'd7;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk_quiet("start_abort_idle");
    // Lone abort in IDLE has no effect.
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk_quiet("abort_idle");

    for (int k = 0; k < 6; k++) begin
      tgt = int'($urandom_range(0, 63));
      t   = CW + PL + ((tgt > MAXV) ? MAXV : tgt) * (PH + PL);
      ab  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, t - 1)) : -1;
      run_seq(tgt, ab, -1);
    end
    idle_cycles(5, "final_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
